// File: rtl/mem_rv.sv
// Word-addressed memory behind valid/ready request and response channels.
// Responses return in acceptance order through a small FIFO; req_ready reserves a slot per request.
module mem_rv #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    wr_rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_wr,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned RSP_DEPTH = RD_LATENCY + 1;
  localparam int unsigned PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  wr;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  in_range;
  logic [IDX_W-1:0]      mem_idx;
  logic [CNT_W-1:0]      outstanding_q;
  rsp_t                  s0_rsp;
  rsp_t                  push_rsp;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign in_range = (32'(addr) < DEPTH);
  assign mem_idx  = IDX_W'(addr);

  // Held low through reset so nothing is accepted, and no memory write happens, while rst is high.
  assign req_ready = !rst && (outstanding_q < CNT_W'(RSP_DEPTH));

  always_ff @(posedge clk) begin
    if (req_fire && wr_rd && in_range) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) begin
          mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured at the accept edge, so it already reflects every earlier write.
  always_comb begin
    s0_rsp.wr   = wr_rd;
    s0_rsp.err  = !in_range;
    s0_rsp.data = '0;
    if (in_range && !wr_rd) begin
      s0_rsp.data = mem[mem_idx];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign push_valid = req_fire;
    assign push_rsp   = s0_rsp;
  end else begin : g_lat2
    logic p1_valid_q;
    rsp_t p1_rsp_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p1_valid_q <= 1'b0;
        p1_rsp_q   <= '0;
      end else begin
        p1_valid_q <= req_fire;
        if (req_fire) begin
          p1_rsp_q <= s0_rsp;
        end
      end
    end

    assign push_valid = p1_valid_q;
    assign push_rsp   = p1_rsp_q;
  end

  rsp_t             fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  rsp_t             head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_q[wr_ptr_q] <= push_rsp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (rsp_fire) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push_valid, rsp_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign rsp_valid = (count_q != '0);
  assign rsp_wr    = rsp_valid ? head.wr : 1'b0;
  assign rsp_err   = rsp_valid ? head.err : 1'b0;
  assign rd_data   = rsp_valid ? head.data : '0;

endmodule

// File: tb/tb_mem_rv.sv
// Bench for mem_rv: dut0 is DEPTH=1000/RD_LATENCY=1, dut1 is DEPTH=1024/RD_LATENCY=2.
// A negedge monitor queues expected responses on accept and pops them on response accept.
module tb_mem_rv;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    rsp_t        e;
  } vec_t;

  localparam rsp_t ACK     = '{wr: 1'b1, err: 1'b0, data: 32'h0};
  localparam rsp_t RD_ERR  = '{wr: 1'b0, err: 1'b1, data: 32'h0};
  localparam rsp_t WR_ERR  = '{wr: 1'b1, err: 1'b1, data: 32'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        wr_rd;
  logic [9:0]  addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rsp_ready;

  logic        rr0, rv0, rw0, re0, rr1, rv1, rw1, re1;
  logic [31:0] rd0, rd1;
  logic        req_ready_m, rsp_valid_m, rsp_wr_m, rsp_err_m;
  logic [31:0] rd_data_m;

  rsp_t cur_exp;
  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   run = 0;
  int   max_run = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_rv #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .RD_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr0), .wr_rd(wr_rd),
    .addr(addr), .wr_data(wr_data), .wr_be(wr_be), .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_wr(rw0), .rsp_err(re0), .rd_data(rd0)
  );

  mem_rv #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024), .RD_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr1), .wr_rd(wr_rd),
    .addr(addr), .wr_data(wr_data), .wr_be(wr_be), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_wr(rw1), .rsp_err(re1), .rd_data(rd1)
  );

  assign req_ready_m = sel ? rr1 : rr0;
  assign rsp_valid_m = sel ? rv1 : rv0;
  assign rsp_wr_m    = sel ? rw1 : rw0;
  assign rsp_err_m   = sel ? re1 : re0;
  assign rd_data_m   = sel ? rd1 : rd0;

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic rsp_t rd_ok(input logic [31:0] d);
    return '{wr: 1'b0, err: 1'b0, data: d};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare responses against the queue, then queue the request accepted this cycle.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (rsp_valid_m) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (rsp_valid_m && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'({rsp_wr_m, rsp_err_m, rd_data_m}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("rsp", 64'({rsp_wr_m, rsp_err_m, rd_data_m}), 64'(exp_q.pop_front()));
        end
      end
      if (req_valid && req_ready_m) exp_q.push_back(cur_exp);
    end
  end

  task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] be, input rsp_t e);
    int n;
    req_valid = 1'b1;
    wr_rd     = w;
    addr      = a;
    wr_data   = d;
    wr_be     = be;
    cur_exp   = e;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready_m) break;
      n++;
      if (n >= 50) begin
        check("req_accept_timeout", 64'(n), 64'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  vec_t vt[12];

  initial begin
    logic [31:0] held;
    int          k;
    int          t0;
    int          vcnt;
    logic        acc;

    vt[0]  = '{1'b1, 10'd7,    32'h11223344, 4'hF, ACK};
    vt[1]  = '{1'b1, 10'd7,    32'hAABBCCDD, 4'h5, ACK};
    vt[2]  = '{1'b0, 10'd7,    32'h0,        4'h0, rd_ok(32'h11BB33DD)};
    vt[3]  = '{1'b1, 10'd7,    32'hFFFFFFFF, 4'h0, ACK};
    vt[4]  = '{1'b0, 10'd7,    32'h0,        4'h0, rd_ok(32'h11BB33DD)};
    vt[5]  = '{1'b1, 10'd999,  32'hCAFEF00D, 4'hF, ACK};
    vt[6]  = '{1'b0, 10'd1000, 32'h0,        4'h0, RD_ERR};
    vt[7]  = '{1'b1, 10'd1023, 32'h12345678, 4'hF, WR_ERR};
    vt[8]  = '{1'b0, 10'd999,  32'h0,        4'h0, rd_ok(32'hCAFEF00D)};
    vt[9]  = '{1'b1, 10'd8,    32'h00000000, 4'hF, ACK};
    vt[10] = '{1'b1, 10'd8,    32'h01020304, 4'hA, ACK};
    vt[11] = '{1'b0, 10'd8,    32'h0,        4'h0, rd_ok(32'h01000300)};

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; wr_rd = 1'b0; addr = '0;
    wr_data = '0; wr_be = '0; rsp_ready = 1'b1; cur_exp = '0;

    #12;
    check("rst_req_ready", 64'(req_ready_m), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_m), 64'(0));
    check("rst_rsp_wr", 64'(rsp_wr_m), 64'(0));
    check("rst_rsp_err", 64'(rsp_err_m), 64'(0));
    check("rst_rd_data", 64'(rd_data_m), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready_m), 64'(1));
    @(posedge clk); #1;

    // Write then read next cycle; read data must be visible one cycle after the read accept.
    issue(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, ACK);
    issue(1'b0, 10'd5, 32'h0, 4'h0, rd_ok(32'hDEADBEEF));
    req_valid = 1'b0;
    @(negedge clk);
    check("raw_lat_valid", 64'(rsp_valid_m), 64'(1));
    check("raw_lat_data", 64'({rsp_wr_m, rd_data_m}), 64'({1'b0, 32'hDEADBEEF}));
    @(posedge clk); #1;
    drain("raw");

    for (int i = 0; i < 12; i++) issue(vt[i].w, vt[i].a, vt[i].d, vt[i].be, vt[i].e);
    req_valid = 1'b0;
    drain("table");

    // RD_LATENCY=2 instance from here on.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) issue(1'b1, 10'(i), pat(i), 4'hF, ACK);
    req_valid = 1'b0;
    drain("fill");
    @(posedge clk); #1;

    max_run = 0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) issue(1'b0, 10'(i), 32'h0, 4'h0, rd_ok(pat(i)));
    check("tput_accept_cycles", 64'(cyc - t0), 64'(16));
    req_valid = 1'b0;
    drain("tput");
    check("tput_no_bubbles", 64'(max_run), 64'(16));

    // Backpressure: with rsp_ready low only RSP_DEPTH=3 reads fit.
    rsp_ready = 1'b0;
    k = 0;
    req_valid = 1'b1; wr_rd = 1'b0; addr = 10'(k); cur_exp = rd_ok(pat(k));
    repeat (8) begin
      @(negedge clk);
      acc = req_ready_m;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        addr = 10'(k);
        cur_exp = rd_ok(pat(k));
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts", 64'(k), 64'(3));
    check("bp_ready_low", 64'(req_ready_m), 64'(0));
    check("bp_head", 64'({rsp_valid_m, rd_data_m}), 64'({1'b1, pat(0)}));
    held = rd_data_m;
    repeat (3) @(negedge clk);
    check("bp_hold", 64'(rd_data_m), 64'(held));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("bp");
    @(negedge clk);
    check("bp_ready_back", 64'(req_ready_m), 64'(1));
    @(posedge clk); #1;

    // Reset with two reads in flight; a write presented during reset must not land.
    rsp_ready = 1'b0;
    issue(1'b0, 10'd3, 32'h0, 4'h0, rd_ok(pat(3)));
    issue(1'b0, 10'd4, 32'h0, 4'h0, rd_ok(pat(4)));
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_pending", 64'(rsp_valid_m), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid_m), 64'(0));
    check("mid_rst_data", 64'({rsp_wr_m, rsp_err_m, rd_data_m}), 64'(0));
    check("mid_rst_ready", 64'(req_ready_m), 64'(0));
    exp_q.delete();
    req_valid = 1'b1; wr_rd = 1'b1; addr = 10'd0; wr_data = 32'hBAD0BAD0; wr_be = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready_m), 64'(1));
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_m) vcnt++;
    end
    check("no_stale_rsp", 64'(vcnt), 64'(0));
    @(posedge clk); #1;
    issue(1'b0, 10'd0, 32'h0, 4'h0, rd_ok(pat(0)));
    req_valid = 1'b0;
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
